// File: rtl/phase_seq.sv
// Multicycle phase sequencer with run/halt/single-step control and a
// retired-instruction counter. All state changes on the falling edge of clk.
module phase_seq #(
  parameter int PHASES    = 4,
  parameter int SW        = (PHASES > 2) ? $clog2(PHASES) : 1,
  parameter int CNT_W     = 16,
  parameter int START_RUN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sm_en,
  input  logic [SW:0]       n_phases,
  input  logic              end_early,
  input  logic              halt_req,
  input  logic              run_req,
  input  logic              step_req,
  output logic [SW-1:0]     sm,
  output logic [PHASES-1:0] sm_onehot,
  output logic              fetch,
  output logic              instr_done,
  output logic [CNT_W-1:0]  instr_cnt,
  output logic              halted
);

  typedef enum logic [1:0] {
    MODE_RUN  = 2'd0,
    MODE_HALT = 2'd1,
    MODE_STEP = 2'd2
  } mode_t;

  localparam logic [SW:0] N_MIN  = (SW+1)'(2);
  localparam logic [SW:0] N_MAX  = (SW+1)'(PHASES);
  localparam logic [SW:0] SM_TOP = (SW+1)'(PHASES - 1);

  mode_t              mode, mode_n;
  logic               halt_pend, halt_pend_n;
  logic [SW-1:0]      sm_n;
  logic [CNT_W-1:0]   instr_cnt_n;
  logic               instr_done_n;
  logic [SW:0]        eff_n;
  logic [SW:0]        sm_ext;
  logic               last;
  logic               adv;

  assign sm_ext = {1'b0, sm};
  assign fetch  = (sm == '0);
  assign halted = (mode == MODE_HALT);

  // Phase index decode for the control-signal decoder.
  always_comb begin
    sm_onehot = '0;
    for (int unsigned i = 0; i < PHASES; i++) begin
      sm_onehot[i] = (sm == i[SW-1:0]);
    end
  end

  // Clamp phase count and derive the last-phase / advance conditions.
  always_comb begin
    eff_n = n_phases;
    if (n_phases < N_MIN) begin
      eff_n = N_MIN;
    end else if (n_phases > N_MAX) begin
      eff_n = N_MAX;
    end
    // >= rather than == so a mid-instruction shrink retires immediately.
    last = (sm_ext >= (eff_n - (SW+1)'(1))) || (end_early && (sm != '0));
    adv  = sm_en && (mode != MODE_HALT);
  end

  // Next-state logic for phase, mode, pending halt, counter and done pulse.
  always_comb begin
    sm_n         = sm;
    mode_n       = mode;
    halt_pend_n  = halt_pend;
    instr_cnt_n  = instr_cnt;
    instr_done_n = 1'b0;
    case (mode)
      MODE_HALT: begin
        if (run_req) begin
          mode_n = MODE_RUN;
        end else if (step_req) begin
          mode_n = MODE_STEP;
        end
      end
      MODE_RUN, MODE_STEP: begin
        if (adv && last) begin
          sm_n         = '0;
          instr_done_n = 1'b1;
          instr_cnt_n  = instr_cnt + CNT_W'(1);
          halt_pend_n  = 1'b0;
          // run_req in STEP cancels the step halt, not a requested one.
          if (((mode == MODE_STEP) && !run_req) || halt_pend || halt_req) begin
            mode_n = MODE_HALT;
          end else begin
            mode_n = MODE_RUN;
          end
        end else begin
          if (adv) begin
            sm_n = sm + SW'(1);
          end
          if (halt_req) begin
            halt_pend_n = 1'b1;
          end
          if (run_req) begin
            mode_n = MODE_RUN;
          end
        end
      end
      default: begin
        mode_n = MODE_HALT;
      end
    endcase
    if (sm_ext > SM_TOP) begin
      sm_n = '0;
    end
  end

  // State registers, synchronous reset on the falling edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      sm         <= '0;
      mode       <= (START_RUN != 0) ? MODE_RUN : MODE_HALT;
      halt_pend  <= 1'b0;
      instr_cnt  <= '0;
      instr_done <= 1'b0;
    end else begin
      sm         <= sm_n;
      mode       <= mode_n;
      halt_pend  <= halt_pend_n;
      instr_cnt  <= instr_cnt_n;
      instr_done <= instr_done_n;
    end
  end

endmodule

// File: tb/tb_phase_seq.sv
// Bench for phase_seq: directed vector table, counter-wrap/reset sequence,
// and randomized stimulus against a behavioural model (two instances).
module tb_phase_seq;

  typedef struct {
    bit       rst;
    bit       en;
    bit [2:0] n;
    bit       ee;
    bit       hr;
    bit       rr;
    bit       sr;
    int       esm;
    bit       edone;
    bit       ehalt;
    int       ecnt;
  } vec_t;

  typedef struct {
    int          phase;
    bit          halted;
    bit          stepping;
    bit          pend;
    bit          done;
    int unsigned count;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst, sm_en, end_early, halt_req, run_req, step_req;
  logic [2:0]  n_phases;

  logic [1:0]  sm_a, sm_b;
  logic [3:0]  oh_a, oh_b;
  logic        fetch_a, fetch_b, done_a, done_b, halted_a, halted_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int checks = 0;
  int errors = 0;

  mdl_t ma, mb;
  vec_t tbl[$];

  always #5 clk = ~clk;

  phase_seq #(.PHASES(4), .CNT_W(16), .START_RUN(1)) u_a (
    .clk(clk), .rst(rst), .sm_en(sm_en), .n_phases(n_phases),
    .end_early(end_early), .halt_req(halt_req), .run_req(run_req),
    .step_req(step_req), .sm(sm_a), .sm_onehot(oh_a), .fetch(fetch_a),
    .instr_done(done_a), .instr_cnt(cnt_a), .halted(halted_a)
  );

  phase_seq #(.PHASES(4), .CNT_W(4), .START_RUN(0)) u_b (
    .clk(clk), .rst(rst), .sm_en(sm_en), .n_phases(n_phases),
    .end_early(end_early), .halt_req(halt_req), .run_req(run_req),
    .step_req(step_req), .sm(sm_b), .sm_onehot(oh_b), .fetch(fetch_b),
    .instr_done(done_b), .instr_cnt(cnt_b), .halted(halted_b)
  );

  function automatic vec_t mk(input bit r, input bit en, input bit [2:0] n,
                              input bit ee, input bit hr, input bit rr, input bit sr,
                              input int esm, input bit ed, input bit eh, input int ec);
    vec_t v;
    v.rst = r; v.en = en; v.n = n; v.ee = ee; v.hr = hr; v.rr = rr; v.sr = sr;
    v.esm = esm; v.edone = ed; v.ehalt = eh; v.ecnt = ec;
    return v;
  endfunction

  // Reference model: one falling edge of the sequencer, from the rules.
  function automatic mdl_t model_next(input mdl_t s, input vec_t v,
                                      input bit start_run, input int cw);
    mdl_t r;
    int   eff;
    r = s;
    r.done = 1'b0;
    if (v.rst) begin
      r.phase = 0; r.count = 0; r.pend = 1'b0;
      r.halted = !start_run; r.stepping = 1'b0;
      return r;
    end
    eff = (v.n < 2) ? 2 : ((v.n > 4) ? 4 : int'(v.n));
    if (r.halted) begin
      if (v.rr) begin
        r.halted = 1'b0; r.stepping = 1'b0;
      end else if (v.sr) begin
        r.halted = 1'b0; r.stepping = 1'b1;
      end
    end else if (v.en && ((r.phase >= eff - 1) || (v.ee && r.phase != 0))) begin
      r.phase = 0;
      r.done  = 1'b1;
      r.count = (r.count + 1) % (32'd1 << cw);
      if ((r.stepping && !v.rr) || r.pend || v.hr) r.halted = 1'b1;
      r.stepping = 1'b0;
      r.pend     = 1'b0;
    end else begin
      if (v.en) r.phase = r.phase + 1;
      if (v.hr) r.pend = 1'b1;
      if (v.rr) r.stepping = 1'b0;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one set of inputs, let one falling edge happen, advance both models.
  task automatic cycle(input vec_t v);
    rst = v.rst; sm_en = v.en; n_phases = v.n; end_early = v.ee;
    halt_req = v.hr; run_req = v.rr; step_req = v.sr;
    @(negedge clk);
    #1;
    ma = model_next(ma, v, 1'b1, 16);
    mb = model_next(mb, v, 1'b0, 4);
  endtask

  task automatic chk_a_model(input string tag);
    chk({tag, ".a.sm"},     32'(sm_a),     32'(ma.phase));
    chk({tag, ".a.oh"},     32'(oh_a),     32'(1) << ma.phase);
    chk({tag, ".a.fetch"},  32'(fetch_a),  32'(ma.phase == 0));
    chk({tag, ".a.done"},   32'(done_a),   32'(ma.done));
    chk({tag, ".a.halted"}, 32'(halted_a), 32'(ma.halted));
    chk({tag, ".a.cnt"},    32'(cnt_a),    ma.count);
  endtask

  task automatic chk_b_model(input string tag);
    chk({tag, ".b.sm"},     32'(sm_b),     32'(mb.phase));
    chk({tag, ".b.oh"},     32'(oh_b),     32'(1) << mb.phase);
    chk({tag, ".b.fetch"},  32'(fetch_b),  32'(mb.phase == 0));
    chk({tag, ".b.done"},   32'(done_b),   32'(mb.done));
    chk({tag, ".b.halted"}, 32'(halted_b), 32'(mb.halted));
    chk({tag, ".b.cnt"},    32'(cnt_b),    mb.count);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    string tag;

    // rst en n ee hr rr sr | sm done halted cnt   (instance a)
    tbl.push_back(mk(1,1,3,0,0,0,0, 0,0,0,0));
    tbl.push_back(mk(0,1,3,0,0,0,0, 1,0,0,0));
    tbl.push_back(mk(0,1,3,0,0,0,0, 2,0,0,0));
    tbl.push_back(mk(0,1,3,0,0,0,0, 0,1,0,1));
    tbl.push_back(mk(0,1,3,0,0,0,0, 1,0,0,1));
    tbl.push_back(mk(0,1,3,0,0,0,0, 2,0,0,1));
    tbl.push_back(mk(0,1,3,0,0,0,0, 0,1,0,2));
    tbl.push_back(mk(0,1,4,0,0,0,0, 1,0,0,2));
    tbl.push_back(mk(0,1,4,0,0,0,0, 2,0,0,2));
    tbl.push_back(mk(0,1,4,0,0,0,0, 3,0,0,2));
    tbl.push_back(mk(0,1,4,0,0,0,0, 0,1,0,3));
    tbl.push_back(mk(0,1,4,0,0,0,0, 1,0,0,3));
    tbl.push_back(mk(0,1,4,1,0,0,0, 0,1,0,4));   // early end at sm=1
    tbl.push_back(mk(0,1,4,1,0,0,0, 1,0,0,4));   // ignored in FETCH
    tbl.push_back(mk(0,1,4,0,0,0,0, 2,0,0,4));
    tbl.push_back(mk(0,1,4,0,0,0,0, 3,0,0,4));
    tbl.push_back(mk(0,1,4,0,0,0,0, 0,1,0,5));
    tbl.push_back(mk(0,1,0,0,0,0,0, 1,0,0,5));   // n=0 clamps to 2
    tbl.push_back(mk(0,1,0,0,0,0,0, 0,1,0,6));
    tbl.push_back(mk(0,1,7,0,0,0,0, 1,0,0,6));   // n=7 clamps to 4
    tbl.push_back(mk(0,1,7,0,0,0,0, 2,0,0,6));
    tbl.push_back(mk(0,1,7,0,0,0,0, 3,0,0,6));
    tbl.push_back(mk(0,1,7,0,0,0,0, 0,1,0,7));
    tbl.push_back(mk(0,1,4,0,0,0,0, 1,0,0,7));
    tbl.push_back(mk(0,1,4,0,0,0,0, 2,0,0,7));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(0,0,4,0,0,0,0, 2,0,0,7));
    tbl.push_back(mk(0,1,4,0,0,0,0, 3,0,0,7));
    tbl.push_back(mk(0,1,4,0,0,0,0, 0,1,0,8));
    tbl.push_back(mk(0,1,4,0,0,0,0, 1,0,0,8));
    tbl.push_back(mk(0,1,4,0,0,0,0, 2,0,0,8));
    tbl.push_back(mk(0,1,2,0,0,0,0, 0,1,0,9));   // shrink below current phase
    tbl.push_back(mk(0,1,3,0,0,0,0, 1,0,0,9));
    tbl.push_back(mk(0,1,3,0,1,0,0, 2,0,0,9));   // halt request mid-instruction
    tbl.push_back(mk(0,1,3,0,0,0,0, 0,1,1,10));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0,1,3,0,0,0,0, 0,0,1,10));
    tbl.push_back(mk(0,1,3,0,0,0,1, 0,0,0,10));  // step: leave HALT, no advance
    tbl.push_back(mk(0,1,3,0,0,0,0, 1,0,0,10));
    tbl.push_back(mk(0,1,3,0,0,0,0, 2,0,0,10));
    tbl.push_back(mk(0,1,3,0,0,0,0, 0,1,1,11));
    tbl.push_back(mk(0,1,3,0,0,0,0, 0,0,1,11));
    tbl.push_back(mk(0,1,3,0,0,1,1, 0,0,0,11));  // run wins over step
    tbl.push_back(mk(0,1,3,0,0,0,0, 1,0,0,11));
    tbl.push_back(mk(0,1,3,0,0,0,0, 2,0,0,11));
    tbl.push_back(mk(0,1,3,0,0,0,0, 0,1,0,12));
    tbl.push_back(mk(0,1,3,0,0,0,0, 1,0,0,12));
    tbl.push_back(mk(0,0,3,0,1,0,0, 1,0,0,12));  // halt request while stalled
    tbl.push_back(mk(0,0,3,0,0,0,0, 1,0,0,12));
    tbl.push_back(mk(0,1,3,0,0,0,0, 2,0,0,12));
    tbl.push_back(mk(0,1,3,0,0,0,0, 0,1,1,13));
    tbl.push_back(mk(0,1,3,0,1,0,0, 0,0,1,13));  // halt_req ignored in HALT
    tbl.push_back(mk(0,1,3,0,0,1,0, 0,0,0,13));
    tbl.push_back(mk(0,1,3,0,0,0,0, 1,0,0,13));
    tbl.push_back(mk(0,1,3,0,0,0,0, 2,0,0,13));
    tbl.push_back(mk(0,1,3,0,0,0,0, 0,1,0,14));
    tbl.push_back(mk(0,1,3,0,0,0,0, 1,0,0,14));
    tbl.push_back(mk(0,1,3,0,0,0,0, 2,0,0,14));
    tbl.push_back(mk(1,1,3,0,0,0,0, 0,0,0,0));   // reset mid-instruction
    tbl.push_back(mk(0,1,3,0,1,0,0, 1,0,0,0));   // halt request in FETCH
    tbl.push_back(mk(0,1,3,0,0,0,0, 2,0,0,0));
    tbl.push_back(mk(0,1,3,0,0,0,0, 0,1,1,1));
    tbl.push_back(mk(0,1,3,0,0,0,1, 0,0,0,1));
    tbl.push_back(mk(0,1,3,0,0,0,0, 1,0,0,1));
    tbl.push_back(mk(0,1,3,0,0,1,0, 2,0,0,1));   // run during STEP
    tbl.push_back(mk(0,1,3,0,0,0,0, 0,1,0,2));
    tbl.push_back(mk(0,1,3,0,0,0,0, 1,0,0,2));

    foreach (tbl[i]) begin
      cycle(tbl[i]);
      tag = $sformatf("vec%0d", i);
      chk({tag, ".sm"},     32'(sm_a),     32'(tbl[i].esm));
      chk({tag, ".oh"},     32'(oh_a),     32'(1) << tbl[i].esm);
      chk({tag, ".fetch"},  32'(fetch_a),  32'(tbl[i].esm == 0));
      chk({tag, ".done"},   32'(done_a),   32'(tbl[i].edone));
      chk({tag, ".halted"}, 32'(halted_a), 32'(tbl[i].ehalt));
      chk({tag, ".cnt"},    32'(cnt_a),    32'(tbl[i].ecnt));
      if (i > 0) chk_b_model(tag);
    end

    // Counter wrap and mid-instruction reset on the CNT_W=4, START_RUN=0 instance.
    cycle(mk(1,1,2,0,0,0,0, 0,0,0,0));
    chk("wrap.rst.halted", 32'(halted_b), 32'd1);
    chk("wrap.rst.cnt",    32'(cnt_b),    32'd0);
    chk("wrap.rst.sm",     32'(sm_b),     32'd0);
    chk("reset.a.halted",  32'(halted_a), 32'd0);
    cycle(mk(0,1,2,0,0,1,0, 0,0,0,0));
    chk("wrap.run.sm",     32'(sm_b),     32'd0);
    chk("wrap.run.halted", 32'(halted_b), 32'd0);
    for (int k = 1; k <= 16; k++) begin
      cycle(mk(0,1,2,0,0,0,0, 0,0,0,0));
      chk($sformatf("wrap%0d.sm1", k), 32'(sm_b), 32'd1);
      cycle(mk(0,1,2,0,0,0,0, 0,0,0,0));
      chk($sformatf("wrap%0d.done", k), 32'(done_b), 32'd1);
      chk($sformatf("wrap%0d.cnt", k), 32'(cnt_b), 32'(k % 16));
    end
    cycle(mk(0,1,3,0,0,0,0, 0,0,0,0));
    cycle(mk(0,1,3,0,0,0,0, 0,0,0,0));
    chk("rstmid.pre.sm", 32'(sm_b), 32'd2);
    cycle(mk(1,1,3,0,0,0,0, 0,0,0,0));
    chk("rstmid.sm",     32'(sm_b),     32'd0);
    chk("rstmid.halted", 32'(halted_b), 32'd1);
    chk("rstmid.cnt",    32'(cnt_b),    32'd0);
    chk("rstmid.done",   32'(done_b),   32'd0);

    // Randomized stimulus against the model.
    for (int i = 0; i < 3000; i++) begin
      v.rst = ($urandom_range(0, 99) == 0);
      v.en  = ($urandom_range(0, 3) != 0);
      v.n   = 3'($urandom_range(0, 7));
      v.ee  = ($urandom_range(0, 7) == 0);
      v.hr  = ($urandom_range(0, 15) == 0);
      v.rr  = ($urandom_range(0, 15) == 0);
      v.sr  = ($urandom_range(0, 5) == 0);
      cycle(v);
      tag = $sformatf("rnd%0d", i);
      chk_a_model(tag);
      chk_b_model(tag);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
